// File: rtl/acia_pkg.sv
// acia_pkg
// Shared definitions for the ACIA serial blocks: receiver FSM states,
// data_bits encodings, the minimum bit-time divisor and the layout of one
// receive FIFO entry.
package acia_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    // data_bits encodings
    localparam logic [1:0] DB5 = 2'd0;
    localparam logic [1:0] DB6 = 2'd1;
    localparam logic [1:0] DB7 = 2'd2;
    localparam logic [1:0] DB8 = 2'd3;

    // Shorter bit times leave no room for a centred start-bit check.
    localparam int MIN_DIV = 4;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } fifo_entry_t;

    // Index of the final data bit for a data_bits encoding.
    function automatic logic [2:0] lastBitIdx(input logic [1:0] db);
        case (db)
            DB5:     return 3'd4;
            DB6:     return 3'd5;
            DB7:     return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/acia_fifo.sv
// acia_fifo
// First-word-fall-through synchronous FIFO shared by the ACIA RX and TX paths.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   i_push      write i_data (accepted when not full, or when a pop frees space)
//   i_data      entry to write
//   i_pop       drop the head entry (ignored while empty)
//   o_data      head entry, valid whenever o_empty is 0
//   o_count     entries held, reaches 2**AW when full
//   o_full      FIFO full
//   o_empty     FIFO empty
module acia_fifo #(
    parameter int AW = 4,
    parameter int W  = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doPop;
    logic          w_doPush;

    // The count has one spare bit, so its MSB alone marks the full state.
    assign o_empty  = (r_count == '0);
    assign o_full   = r_count[AW];
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count moves only on push-xor-pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/acia_rx_fifo.sv
// acia_rx_fifo
// Configurable asynchronous serial receiver (5-8 data bits, optional parity,
// 1 or 2 stop bits, runtime divisor) feeding a FWFT receive FIFO.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   pclk            clock enable; the line filter and FSM advance only when high
//   rx_serial       raw serial line, idle high
//   divisor         pclk ticks per bit (values below 4 act as 4)
//   data_bits       0..3 -> 5..8 data bits
//   parity_en/odd   parity present / odd parity
//   two_stop        two stop bits
//   rd_stb, err_clr pop the FIFO head / clear sticky flags (clk domain)
//   rx_dat, rx_perr FIFO head data and parity-error tag
//   rx_avail, rx_full, fifo_cnt  FIFO status
//   frame_err, overrun, break_det  sticky error flags
module acia_rx_fifo import acia_pkg::*; #(
    parameter int DIV_W    = 16,
    parameter int FIFO_AW  = 4,
    parameter int SYNC_LEN = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pclk,
    input  logic               rx_serial,
    input  logic [DIV_W-1:0]   divisor,
    input  logic [1:0]         data_bits,
    input  logic               parity_en,
    input  logic               parity_odd,
    input  logic               two_stop,
    input  logic               rd_stb,
    input  logic               err_clr,
    output logic [7:0]         rx_dat,
    output logic               rx_perr,
    output logic               rx_avail,
    output logic               rx_full,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic               frame_err,
    output logic               overrun,
    output logic               break_det
);

    localparam int                HR_W   = $clog2(SYNC_LEN + 1);
    localparam logic [HR_W-1:0]   HR_MAX = HR_W'(SYNC_LEN);

    logic [SYNC_LEN-1:0] r_sync;
    logic                r_filt;
    logic [HR_W-1:0]     r_highRun;
    logic                r_armed;

    rx_state_t           r_state;
    rx_state_t           w_stateNext;
    logic [DIV_W-1:0]    r_rcnt;
    logic [DIV_W-1:0]    r_div;
    logic [1:0]          r_dataBits;
    logic                r_parEn;
    logic                r_parOdd;
    logic                r_twoStop;
    logic [2:0]          r_bitCnt;
    logic [7:0]          r_shift;
    logic                r_parBit;
    logic                r_perr;
    logic                r_stopLow;
    logic                r_stopIdx;

    logic                r_frameErr;
    logic                r_overrun;
    logic                r_breakDet;

    logic [DIV_W-1:0]    w_divEff;
    logic                w_startDet;
    logic                w_tick0;
    logic                w_finalStop;
    logic                w_frameBad;
    logic                w_isBreak;
    logic                w_perrCalc;
    logic                w_push;
    logic                w_setFerr;
    logic                w_setBrk;
    logic                w_setOvr;

    fifo_entry_t         w_pushEntry;
    fifo_entry_t         w_headEntry;
    logic                w_fifoFull;
    logic                w_fifoEmpty;
    logic [FIFO_AW:0]    w_fifoCnt;

    assign w_divEff    = (divisor < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divisor;
    assign w_startDet  = r_armed && !r_filt;
    assign w_tick0     = pclk && (r_rcnt == '0);
    assign w_finalStop = !r_twoStop || r_stopIdx;
    assign w_frameBad  = !r_filt || (r_twoStop && r_stopLow);
    assign w_isBreak   = !r_filt && (!r_twoStop || r_stopLow) &&
                         (r_shift == 8'h00) && (!r_parEn || !r_parBit);
    assign w_perrCalc  = ((^r_shift) ^ r_filt) != r_parOdd;

    // Line filter. r_filt resets to idle, which says nothing about the real
    // line after a mid-frame reset, so start detection also waits for a fresh
    // run of SYNC_LEN high samples (r_armed) before trusting a low level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync    <= '1;
            r_filt    <= 1'b1;
            r_highRun <= '0;
            r_armed   <= 1'b0;
        end else if (pclk) begin
            r_sync <= {r_sync[SYNC_LEN-2:0], rx_serial};
            if (r_sync == '0) begin
                r_filt <= 1'b0;
            end else if (&r_sync) begin
                r_filt <= 1'b1;
            end
            if (!rx_serial) begin
                r_highRun <= '0;
            end else if (r_highRun != HR_MAX) begin
                r_highRun <= r_highRun + HR_W'(1);
            end
            if (r_highRun == HR_MAX) begin
                r_armed <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // FSM next-state logic; every transition is on a pclk tick.
    always_comb begin
        w_stateNext = r_state;
        if (pclk) begin
            case (r_state)
                IDLE:     if (w_startDet) w_stateNext = START;
                START:    if (r_rcnt == '0) w_stateNext = r_filt ? IDLE : DATA;
                DATA:     if (r_rcnt == '0 && r_bitCnt == lastBitIdx(r_dataBits))
                              w_stateNext = r_parEn ? PARITY : STOP;
                PARITY:   if (r_rcnt == '0) w_stateNext = STOP;
                STOP:     if (r_rcnt == '0 && w_finalStop)
                              w_stateNext = w_isBreak ? BRK_WAIT : IDLE;
                BRK_WAIT: if (r_filt) w_stateNext = IDLE;
                default:  w_stateNext = IDLE;
            endcase
        end
    end

    // Frame datapath. The format is captured at the start edge so that
    // register writes mid-frame only affect the next frame. Data bits land
    // at their own index, leaving unused upper bits zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rcnt     <= '0;
            r_div      <= DIV_W'(MIN_DIV);
            r_dataBits <= DB8;
            r_parEn    <= 1'b0;
            r_parOdd   <= 1'b0;
            r_twoStop  <= 1'b0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_parBit   <= 1'b0;
            r_perr     <= 1'b0;
            r_stopLow  <= 1'b0;
            r_stopIdx  <= 1'b0;
        end else if (pclk) begin
            if (r_state == IDLE) begin
                if (w_startDet) begin
                    r_rcnt     <= w_divEff >> 1;
                    r_div      <= w_divEff;
                    r_dataBits <= data_bits;
                    r_parEn    <= parity_en;
                    r_parOdd   <= parity_odd;
                    r_twoStop  <= two_stop;
                    r_bitCnt   <= '0;
                    r_shift    <= '0;
                    r_parBit   <= 1'b0;
                    r_perr     <= 1'b0;
                    r_stopLow  <= 1'b0;
                    r_stopIdx  <= 1'b0;
                end
            end else if (r_rcnt != '0) begin
                r_rcnt <= r_rcnt - DIV_W'(1);
            end else begin
                r_rcnt <= r_div - DIV_W'(1);
                case (r_state)
                    DATA: begin
                        r_shift[r_bitCnt] <= r_filt;
                        r_bitCnt          <= r_bitCnt + 3'd1;
                    end
                    PARITY: begin
                        r_parBit <= r_filt;
                        r_perr   <= w_perrCalc;
                    end
                    STOP: begin
                        r_stopLow <= !r_filt;
                        r_stopIdx <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM outputs: frame verdict at the final stop sample.
    always_comb begin
        w_push    = 1'b0;
        w_setFerr = 1'b0;
        w_setBrk  = 1'b0;
        if (w_tick0 && r_state == STOP && w_finalStop) begin
            if (w_isBreak) begin
                w_setBrk = 1'b1;
            end else if (w_frameBad) begin
                w_setFerr = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end
    end

    // A full FIFO only drops the frame if no read frees a slot this cycle.
    assign w_setOvr = w_push && w_fifoFull && !rd_stb;

    // Sticky flags; a new event beats a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
            r_breakDet <= 1'b0;
        end else begin
            if (w_setFerr)    r_frameErr <= 1'b1;
            else if (err_clr) r_frameErr <= 1'b0;
            if (w_setOvr)     r_overrun  <= 1'b1;
            else if (err_clr) r_overrun  <= 1'b0;
            if (w_setBrk)     r_breakDet <= 1'b1;
            else if (err_clr) r_breakDet <= 1'b0;
        end
    end

    assign w_pushEntry.perr = r_perr;
    assign w_pushEntry.data = r_shift;

    acia_fifo #(
        .AW (FIFO_AW),
        .W  ($bits(fifo_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_pushEntry),
        .i_pop   (rd_stb),
        .o_data  (w_headEntry),
        .o_count (w_fifoCnt),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    // Head is masked while empty so stale storage never shows on the bus.
    assign rx_avail  = !w_fifoEmpty;
    assign rx_full   = w_fifoFull;
    assign fifo_cnt  = w_fifoCnt;
    assign rx_dat    = rx_avail ? w_headEntry.data : 8'h00;
    assign rx_perr   = rx_avail ? w_headEntry.perr : 1'b0;
    assign frame_err = r_frameErr;
    assign overrun   = r_overrun;
    assign break_det = r_breakDet;

endmodule

// File: tb/tb_acia_rx_fifo.sv
// tb_acia_rx_fifo
// Self-checking bench for acia_rx_fifo: frames are driven bit by bit on
// rx_serial, accepted frames are queued as expected FIFO entries and
// compared when the bench reads the FIFO head.
module tb_acia_rx_fifo;

    localparam int DIV_W   = 16;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int BIT     = 16;

    logic               clk;
    logic               reset;
    logic               pclk;
    logic               rx_serial;
    logic [DIV_W-1:0]   divisor;
    logic [1:0]         data_bits;
    logic               parity_en;
    logic               parity_odd;
    logic               two_stop;
    logic               rd_stb;
    logic               err_clr;
    logic [7:0]         rx_dat;
    logic               rx_perr;
    logic               rx_avail;
    logic               rx_full;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               frame_err;
    logic               overrun;
    logic               break_det;

    int                 checkCount;
    int                 errorCount;
    logic [8:0]         expQ[$];
    logic               expOverrun;

    acia_rx_fifo #(
        .DIV_W    (DIV_W),
        .FIFO_AW  (FIFO_AW),
        .SYNC_LEN (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pclk       (pclk),
        .rx_serial  (rx_serial),
        .divisor    (divisor),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .rd_stb     (rd_stb),
        .err_clr    (err_clr),
        .rx_dat     (rx_dat),
        .rx_perr    (rx_perr),
        .rx_avail   (rx_avail),
        .rx_full    (rx_full),
        .fifo_cnt   (fifo_cnt),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .break_det  (break_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Hold the line at v for n clocks; called at a negedge, returns at one.
    task automatic driveLine(input logic v, input int n);
        rx_serial = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic setFormat(input logic [1:0] db, input logic pe,
                             input logic po, input logic ts);
        data_bits  = db;
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
    endtask

    // Drive one frame followed by two idle bit times. A frame the receiver
    // should accept is queued, or marks an expected overrun when full.
    task automatic applyStimulus(input logic [7:0] d, input int nbits,
                                 input logic parBit, input logic stopBit,
                                 input logic expPush, input logic expPerr);
        if (expPush) begin
            if (expQ.size() < DEPTH) expQ.push_back({expPerr, d});
            else                     expOverrun = 1'b1;
        end
        driveLine(1'b0, BIT);
        for (int i = 0; i < nbits; i++) driveLine(d[i], BIT);
        if (parity_en) driveLine(parBit, BIT);
        driveLine(stopBit, BIT);
        if (two_stop) driveLine(1'b1, BIT);
        driveLine(1'b1, 2 * BIT);
    endtask

    task automatic readCheck(input string tag);
        logic [8:0] exp;
        exp = 9'h000;
        if (expQ.size() > 0) exp = expQ.pop_front();
        checkOutput({tag, "_avail"}, 32'(rx_avail), 32'd1);
        checkOutput({tag, "_dat"},   32'(rx_dat),   32'(exp[7:0]));
        checkOutput({tag, "_perr"},  32'(rx_perr),  32'(exp[8]));
        rd_stb = 1'b1;
        @(negedge clk);
        rd_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulseErrClr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {rx_dat, rx_perr, rx_avail, rx_full, fifo_cnt,
                          frame_err, overrun, break_det}, 32'd0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        expOverrun = 1'b0;
        reset      = 1'b1;
        pclk       = 1'b1;
        rx_serial  = 1'b1;
        divisor    = DIV_W'(BIT);
        rd_stb     = 1'b0;
        err_clr    = 1'b0;
        setFormat(2'd3, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkAllZero("reset_outputs");
        reset = 1'b0;
        driveLine(1'b1, 3 * BIT);
        checkAllZero("idle_after_reset");

        // 8N1 single byte
        applyStimulus(8'hA5, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("8n1_cnt", 32'(fifo_cnt), 32'd1);
        readCheck("8n1_a5");
        checkOutput("8n1_empty_after_read", 32'(rx_avail), 32'd0);

        // 7E2 with wrong, then correct, parity
        setFormat(2'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(8'h41, 7, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("7e2_cnt", 32'(fifo_cnt), 32'd2);
        checkOutput("7e2_ferr", 32'(frame_err), 32'd0);
        readCheck("7e2_bad_par");
        readCheck("7e2_good_par");

        // Glitches and a filtered-through false start are all ignored
        setFormat(2'd3, 1'b0, 1'b0, 1'b0);
        driveLine(1'b0, 5);
        driveLine(1'b1, 2 * BIT);
        driveLine(1'b0, 4);
        driveLine(1'b1, 2 * BIT);
        driveLine(1'b0, 8);
        driveLine(1'b1, 3 * BIT);
        checkOutput("glitch_cnt", 32'(fifo_cnt), 32'd0);
        checkOutput("glitch_flags", {frame_err, overrun, break_det}, 32'd0);
        applyStimulus(8'h96, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        readCheck("after_glitch");

        // Fill past capacity: 17 frames, the last one overruns
        for (int b = 0; b < 17; b++) begin
            applyStimulus(8'(b), 8, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("fill_cnt", 32'(fifo_cnt), 32'(DEPTH));
        checkOutput("fill_full", 32'(rx_full), 32'd1);
        checkOutput("fill_overrun", 32'(overrun), 32'(expOverrun));
        for (int b = 0; b < DEPTH; b++) begin
            readCheck("fill_drain");
        end
        checkOutput("drain_empty", 32'(rx_avail), 32'd0);
        pulseErrClr();
        expOverrun = 1'b0;
        checkOutput("overrun_cleared", 32'(overrun), 32'(expOverrun));

        // Break: line low for 20 bit times
        driveLine(1'b0, 20 * BIT);
        driveLine(1'b1, 4 * BIT);
        checkOutput("break_det", 32'(break_det), 32'd1);
        checkOutput("break_ferr", 32'(frame_err), 32'd0);
        checkOutput("break_cnt", 32'(fifo_cnt), 32'd0);
        applyStimulus(8'h55, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        readCheck("after_break");
        pulseErrClr();
        checkOutput("break_cleared", 32'(break_det), 32'd0);

        // Framing error leaves FIFO untouched; clearing keeps contents
        applyStimulus(8'h77, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ferr_set", 32'(frame_err), 32'd1);
        checkOutput("ferr_cnt", 32'(fifo_cnt), 32'd1);
        pulseErrClr();
        checkOutput("ferr_cleared", 32'(frame_err), 32'd0);
        checkOutput("ferr_clr_cnt", 32'(fifo_cnt), 32'd1);
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a 0x00 frame
        driveLine(1'b0, 4 * BIT);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("midframe_reset");
        expQ.delete();
        reset = 1'b0;
        driveLine(1'b0, 5 * BIT);
        driveLine(1'b1, 12 * BIT);
        checkOutput("post_reset_cnt", 32'(fifo_cnt), 32'd0);
        checkOutput("post_reset_flags", {frame_err, overrun, break_det}, 32'd0);
        applyStimulus(8'h12, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("post_reset_frame_cnt", 32'(fifo_cnt), 32'd1);
        readCheck("post_reset_12");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/acia_rx_fifo.md
Name: acia_rx_fifo

Overview:
Parametrised asynchronous serial receiver that succeeds the fixed 9600-8N1 receiver in the ACIA peripheral.
- Runtime baud divisor; 5-8 data bits; optional even/odd parity; 1 or 2 stop bits.
- Start-bit validation, break detection, and a first-word-fall-through receive FIFO with overrun tracking.
- Sits between the raw RX pin and the ACIA register interface, advancing only on the peripheral clock enable.

Parameters:
DIV_W, 16, width of divisor; bit time in pclk ticks
FIFO_AW, 4, log2 FIFO depth (default 16 entries)
SYNC_LEN, 8, deglitch shift-register length in pclk ticks

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pclk  in  1  peripheral clock enable; all state except FIFO read/clear advances only when high
rx_serial  in  1  raw serial input, idle high
divisor  in  DIV_W  pclk ticks per bit; values below 4 treated as 4
data_bits  in  2  0..3 selects 5..8 data bits
parity_en  in  1  parity bit present
parity_odd  in  1  1 = odd parity, 0 = even
two_stop  in  1  two stop bits
rd_stb  in  1  pop FIFO head (clk domain, 1-cycle pulse)
err_clr  in  1  clear sticky error flags
rx_dat  out  8  FIFO head data; zero-extended above data_bits
rx_perr  out  1  parity-error tag of FIFO head
rx_avail  out  1  FIFO not empty
rx_full  out  1  FIFO full
fifo_cnt  out  FIFO_AW+1  entries held
frame_err  out  1  sticky: stop bit sampled low on a non-break frame
overrun  out  1  sticky: completed frame discarded because FIFO full
break_det  out  1  sticky: break received

Behaviour:
Reset:
- All outputs 0.
- Filtered line state 1; sync register all ones; FSM IDLE; FIFO empty.

Deglitch:
- Each pclk tick, shift rx_serial into a SYNC_LEN register.
- Filtered state goes to 0 only when all bits are 0, and to 1 only when all bits are 1.

Frame configuration:
- divisor, data_bits, parity_en, parity_odd and two_stop are latched on IDLE->START.
- Changes mid-frame take effect on the next frame.

FSM (states IDLE, START, DATA, PARITY, STOP, BRK_WAIT; bit counter rcnt decrements per pclk):
- IDLE: on filtered 0, load rcnt = div>>1, go START.
- START: at rcnt==0, if filtered still 0, load rcnt = div-1 and go DATA; else return to IDLE (false start, no flag).
- DATA: sample at rcnt==0, LSB first, into an 8-bit shift register; after data_bits+5 samples go PARITY if parity_en, else STOP.
- PARITY: sample one bit. perr = (XOR of data bits XOR sampled bit) != parity_odd.
- STOP: sample first stop bit.
  - If two_stop, sample the second as well; frame is bad if either is 0.
  - Frame result is decided at the final stop sample.
- Result handling:
  - Break: all data bits 0, parity bit (if present) 0, and stop 0. Set break_det, push nothing, go BRK_WAIT.
  - Bad stop, not break: set frame_err, push nothing, go IDLE.
  - Good frame: push {perr, data}. If FIFO full (after any same-cycle pop), set overrun and discard. Go IDLE.
- BRK_WAIT: stay until filtered state is 1, then go IDLE.
- The state machine re-arms for a new start bit on the pclk tick after the last stop sample.

FIFO:
- Depth 2^FIFO_AW, 9 bits wide, first-word fall-through.
- rx_dat/rx_perr are valid whenever rx_avail is 1.
- Push at a stop-sample tick; rx_avail/fifo_cnt update on the following clk edge.
- rd_stb while empty is ignored.
- Pop and push in the same cycle: count unchanged. When full, the pop frees space and the push succeeds with no overrun.
- Pointers wrap modulo depth; fifo_cnt reaches 2^FIFO_AW when full.

Sticky flags:
- Cleared by err_clr.
- If a set and err_clr coincide, set wins.
- Clearing flags does not affect FIFO contents.

Async reset mid-frame:
- Frame discarded, FIFO emptied.
- After deassertion, the receiver ignores the line until filtered idle (high) has been seen, so no partial frame is received.

Decomposition:
- Shared package acia_pkg holds:
  - FSM state enum;
  - data_bits encoding constants (DB5..DB8);
  - minimum-divisor constant 4;
  - FIFO entry struct {perr, data[7:0]}.
- One natural sub-module: acia_fifo, a parametrised FWFT synchronous FIFO with push, pop, count, full and empty, reusable by the TX side.

Test Plan (divisor=16, pclk tied high unless stated):
- 8N1, send 0xA5 -> rx_avail=1, rx_dat=0xA5, rx_perr=0, fifo_cnt=1; rd_stb -> rx_avail=0.
- 7E2 (data_bits=2, parity_en=1, parity_odd=0), send 0x41 with parity bit 1 -> rx_dat=0x41, rx_perr=1. Same frame with parity 0 -> rx_perr=0. Neither sets frame_err.
- Low glitch of 5 pclk ticks, then a 4-tick low pulse shorter than half a bit -> no push, no flags, FSM back in IDLE.
- Send 17 bytes 0x00..0x10 without reads -> fifo_cnt=16, rx_full=1, overrun=1, head 0x00. Pop all 16 -> 0x00..0x0F in order. err_clr -> overrun=0.
- Line held low 20 bit times, then high -> break_det=1, no push, frame_err=0. Next 0x55 frame received normally.
- Send 0x3C with stop bit 0 -> frame_err=1, fifo_cnt unchanged. Assert reset mid-frame of a following byte -> all outputs 0, and the next clean 0x12 frame is received correctly.
